// File: rtl/logic_ram_loader_if.sv
// Host byte link and logic-controller bank signals for logic_ram_loader.
// The master modport is the loader side; the slave modport is the host/controller side.
interface logic_ram_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        Logic_req;
  logic [15:0] Logic_Addr;
  logic [7:0]  Logic_Data;
  logic        Logic_Wren;
  logic [7:0]  Logic_Init_Ctrl;
  logic        Logic_Init_wr;
  logic        load_busy;
  logic        load_done;
  logic        load_err;

  modport master (
    input  rx_data, rx_valid, Logic_req,
    output rx_ready, Logic_Addr, Logic_Data, Logic_Wren, Logic_Init_Ctrl,
           Logic_Init_wr, load_busy, load_done, load_err
  );

  modport slave (
    output rx_data, rx_valid, Logic_req,
    input  rx_ready, Logic_Addr, Logic_Data, Logic_Wren, Logic_Init_Ctrl,
           Logic_Init_wr, load_busy, load_done, load_err
  );
endinterface

// File: rtl/logic_ram_loader.sv
// Write-side master for the logic-engine programming bus: framed host bytes -> RAM writes / init updates.
// Define LOGIC_LOADER_CSUM_EN to require a trailing checksum byte on every frame.
module logic_ram_loader #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned MAX_LEN     = 1024,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input logic                clk,
  input logic                rstn,
  logic_ram_loader_if.master bus
);
  localparam logic [15:0] LP_MAX_LEN = 16'(MAX_LEN);
  localparam logic [15:0] LP_TMO     = 16'(TIMEOUT_CYC);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_CHAN, S_ADRH, S_ADRL, S_LENH, S_LENL, S_DATA, S_INIT
`ifdef LOGIC_LOADER_CSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_rdy_en;
  logic [15:0] r_tmo;
  logic [2:0]  r_ch;
  logic [9:0]  r_off;
  logic [7:0]  r_lenh;
  logic [10:0] r_rem;
  logic [15:0] r_addr;
  logic [7:0]  r_data;
  logic        r_wren;
  logic [7:0]  r_init_ctrl;
  logic        r_init_wr;
  logic        r_done;
  logic        r_err;
`ifdef LOGIC_LOADER_CSUM_EN
  logic [7:0]  r_sum;
  logic [7:0]  r_val;
  logic        r_is_init;
`endif

  logic        w_rdy, w_acc, w_tmo_hit;
  logic        w_wr, w_init, w_done, w_err;
  logic [7:0]  w_byte, w_init_val;
  logic [15:0] w_len;

  // rx_ready is held low through reset and the first clock after release.
  assign w_rdy     = r_rdy_en & ~bus.Logic_req;
  assign w_acc     = bus.rx_valid & w_rdy;
  assign w_byte    = bus.rx_data;
  assign w_len     = {r_lenh, w_byte};
  assign w_tmo_hit = (r_state != S_IDLE) & ~bus.Logic_req & ~w_acc & (r_tmo == LP_TMO);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_init      = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_init_val  = w_byte;
    if (w_tmo_hit) begin
      w_state_nxt = S_IDLE;
      w_err       = 1'b1;
    end else if (w_acc) begin
      case (r_state)
        S_IDLE: if (w_byte == SYNC_BYTE) w_state_nxt = S_CMD;
        S_CMD: begin
          if (w_byte == 8'h01)      w_state_nxt = S_CHAN;
          else if (w_byte == 8'h02) w_state_nxt = S_INIT;
          else begin
            w_state_nxt = S_IDLE;
            w_err       = 1'b1;
          end
        end
        S_CHAN: begin
          w_state_nxt = (|w_byte[7:3]) ? S_IDLE : S_ADRH;
          w_err       = |w_byte[7:3];
        end
        S_ADRH: begin
          w_state_nxt = (|w_byte[7:2]) ? S_IDLE : S_ADRL;
          w_err       = |w_byte[7:2];
        end
        S_ADRL: w_state_nxt = S_LENH;
        S_LENH: w_state_nxt = S_LENL;
        S_LENL: begin
          if (w_len == 16'd0 || w_len > LP_MAX_LEN) begin
            w_state_nxt = S_IDLE;
            w_err       = 1'b1;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          w_wr = 1'b1;
          if (r_rem == 11'd1) begin
`ifdef LOGIC_LOADER_CSUM_EN
            w_state_nxt = S_CSUM;
`else
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
`endif
          end
        end
`ifdef LOGIC_LOADER_CSUM_EN
        S_INIT: w_state_nxt = S_CSUM;
        // INIT value was parked in r_val and is only published once the sum verifies.
        S_CSUM: begin
          w_state_nxt = S_IDLE;
          if ((r_sum + w_byte) == 8'h00) begin
            w_done     = 1'b1;
            w_init     = r_is_init;
            w_init_val = r_val;
          end else begin
            w_err = 1'b1;
          end
        end
`else
        S_INIT: begin
          w_state_nxt = S_IDLE;
          w_init      = 1'b1;
          w_done      = 1'b1;
        end
`endif
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdy_en    <= 1'b0;
      r_tmo       <= '0;
      r_ch        <= '0;
      r_off       <= '0;
      r_lenh      <= '0;
      r_rem       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_wren      <= 1'b0;
      r_init_ctrl <= '0;
      r_init_wr   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rdy_en  <= 1'b1;
      r_wren    <= w_wr;
      r_init_wr <= w_init;
      r_done    <= w_done;
      if (w_acc || w_tmo_hit || r_state == S_IDLE) r_tmo <= '0;
      else if (!bus.Logic_req)                     r_tmo <= r_tmo + 16'd1;
      if (w_err)                                                r_err <= 1'b1;
      else if (w_acc && r_state == S_IDLE && w_byte == SYNC_BYTE) r_err <= 1'b0;
      if (w_init) r_init_ctrl <= w_init_val;
      if (w_acc) begin
        case (r_state)
          S_CHAN: r_ch        <= w_byte[2:0];
          S_ADRH: r_off[9:8]  <= w_byte[1:0];
          S_ADRL: r_off[7:0]  <= w_byte;
          S_LENH: r_lenh      <= w_byte;
          S_LENL: r_rem       <= w_len[10:0];
          S_DATA: begin
            r_addr <= {3'b000, r_ch, r_off};
            r_data <= w_byte;
            r_off  <= r_off + 10'd1;
            r_rem  <= r_rem - 11'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LOGIC_LOADER_CSUM_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sum     <= '0;
      r_val     <= '0;
      r_is_init <= 1'b0;
    end else if (w_acc) begin
      r_sum <= (r_state == S_IDLE) ? 8'h00 : r_sum + w_byte;
      if (r_state == S_CMD)  r_is_init <= (w_byte == 8'h02);
      if (r_state == S_INIT) r_val     <= w_byte;
    end
  end
`endif

  assign bus.rx_ready        = w_rdy;
  assign bus.Logic_Addr      = r_addr;
  assign bus.Logic_Data      = r_data;
  assign bus.Logic_Wren      = r_wren;
  assign bus.Logic_Init_Ctrl = r_init_ctrl;
  assign bus.Logic_Init_wr   = r_init_wr;
  assign bus.load_busy       = (r_state != S_IDLE);
  assign bus.load_done       = r_done;
  assign bus.load_err        = r_err;
endmodule
